// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM states and bit-timing helper.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  function automatic int unsigned clks_per_bit(input int unsigned clock_freq,
                                               input int unsigned bit_rate);
    return clock_freq / bit_rate;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; head always presents the entry at the read pointer.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_data,
  input  logic                           pop,
  output logic [WIDTH-1:0]               head,
  output logic                           empty,
  output logic                           full,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr;
  logic [AW-1:0]               rd_ptr;
  logic                        do_push;
  logic                        do_pop;

  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only legal when a pop frees the slot this cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (!do_push && do_pop) begin
        count <= count - 1'b1;
      end
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with rx synchroniser, sticky error flags and a show-ahead byte FIFO.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ       = 50000000,
  parameter int unsigned BIT_RATE         = 115200,
  parameter int unsigned UART_BUFFER_SIZE = 16
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  rx,
  input  logic                                  rd_en,
  input  logic                                  clr_err,
  output logic [7:0]                            rd_data,
  output logic                                  empty,
  output logic                                  full,
  output logic [$clog2(UART_BUFFER_SIZE+1)-1:0] count,
  output logic                                  frame_error,
  output logic                                  overrun
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLOCK_FREQ, BIT_RATE);
  localparam int unsigned BW           = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] HALF_BIT   = BW'(CLKS_PER_BIT/2 - 1);
  localparam logic [BW-1:0] FULL_BIT   = BW'(CLKS_PER_BIT - 1);

  logic          rx_meta, rx_sync, rx_prev;
  uart_state_t   state, state_d;
  logic [BW-1:0] baud_cnt, baud_d;
  logic [2:0]    bit_idx, bit_d;
  logic [7:0]    shreg, shreg_d;
  logic          push, set_fe, set_ov;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else begin
      state    <= state_d;
      baud_cnt <= baud_d;
      bit_idx  <= bit_d;
      shreg    <= shreg_d;
    end
  end

  always_comb begin
    state_d = state;
    baud_d  = baud_cnt;
    bit_d   = bit_idx;
    shreg_d = shreg;
    push    = 1'b0;
    set_fe  = 1'b0;
    set_ov  = 1'b0;
    unique case (state)
      IDLE: begin
        if (rx_prev && !rx_sync) begin
          baud_d  = HALF_BIT;
          state_d = START;
        end
      end
      START: begin
        if (baud_cnt == '0) begin
          if (!rx_sync) begin
            state_d = DATA;
            bit_d   = '0;
            baud_d  = FULL_BIT;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_cnt - 1'b1;
        end
      end
      DATA: begin
        if (baud_cnt == '0) begin
          shreg_d[bit_idx] = rx_sync;
          baud_d           = FULL_BIT;
          bit_d            = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          baud_d = baud_cnt - 1'b1;
        end
      end
      STOP: begin
        if (baud_cnt == '0) begin
          // Back to IDLE on the sample itself so an immediate next start bit is seen.
          state_d = IDLE;
          if (!rx_sync) begin
            set_fe = 1'b1;
          end else if (!full || rd_en) begin
            push = 1'b1;
          end else begin
            set_ov = 1'b1;
          end
        end else begin
          baud_d = baud_cnt - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      frame_error <= set_fe || (frame_error && !clr_err);
      overrun     <= set_ov || (overrun && !clr_err);
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (UART_BUFFER_SIZE)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (shreg),
    .pop       (rd_en),
    .head      (rd_data),
    .empty     (empty),
    .full      (full),
    .count     (count)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo at 10 clocks per bit.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       rd_en;
  logic       clr_err;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       frame_error;
  logic       overrun;

  logic       mon_rd;
  logic       stim_rd;
  logic       drain_en;
  logic [7:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;

  assign rd_en = mon_rd | stim_rd;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLOCK_FREQ       (1000000),
    .BIT_RATE         (100000),
    .UART_BUFFER_SIZE (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .rd_en       (rd_en),
    .clr_err     (clr_err),
    .rd_data     (rd_data),
    .empty       (empty),
    .full        (full),
    .count       (count),
    .frame_error (frame_error),
    .overrun     (overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Monitor: whenever draining is enabled and the FIFO shows a byte, compare and pop it.
  initial begin
    mon_rd = 1'b0;
    forever begin
      @(negedge clk);
      mon_rd = 1'b0;
      if (drain_en && reset && !empty) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_byte: got %02h required none", rd_data);
        end else begin
          check("rd_data", {24'd0, rd_data}, {24'd0, exp_q.pop_front()});
        end
        mon_rd = 1'b1;
      end
    end
  end

  // Caller is at a negedge; returns at the negedge ending the stop bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input logic store, input logic pop_at_stop);
    if (store) exp_q.push_back(b);
    rx = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (10) @(negedge clk);
    end
    rx = stop_bit;
    if (pop_at_stop) begin
      // The stop bit is sampled on the 98th rising edge after the start bit is driven.
      repeat (7) @(negedge clk);
      check("stop_pop_head", {24'd0, rd_data}, {24'd0, exp_q.pop_front()});
      stim_rd = 1'b1;
      @(negedge clk);
      stim_rd = 1'b0;
      repeat (2) @(negedge clk);
    end else begin
      repeat (10) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    drain_en = 1'b1;
    while ((exp_q.size() != 0 || !empty) && n < 300) begin
      @(negedge clk);
      n++;
    end
    drain_en = 1'b0;
    check({tag, "_drain_done"}, 32'(n < 300), 32'd1);
    @(negedge clk);
    check({tag, "_drain_count"}, 32'(count), 32'd0);
    check({tag, "_drain_empty"}, 32'(empty), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset    = 1'b0;
    rx       = 1'b1;
    clr_err  = 1'b0;
    stim_rd  = 1'b0;
    drain_en = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'h00);
    check("rst_frame_error", 32'(frame_error), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);

    // Single valid frame.
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
    check("s1_count", 32'(count), 32'd1);
    check("s1_empty", 32'(empty), 32'd0);
    check("s1_head", 32'(rd_data), 32'hA5);
    check("s1_frame_error", 32'(frame_error), 32'd0);
    check("s1_overrun", 32'(overrun), 32'd0);
    idle(5);
    drain("s1");

    // Fill to full back-to-back, then one more byte that must be dropped.
    for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b1, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
    idle(5);
    check("s2_full", 32'(full), 32'd1);
    check("s2_count", 32'(count), 32'd16);
    check("s2_overrun", 32'(overrun), 32'd1);
    check("s2_frame_error", 32'(frame_error), 32'd0);
    drain("s2");
    check("s2_overrun_sticky", 32'(overrun), 32'd1);
    pulse_clr();
    check("s2_overrun_clr", 32'(overrun), 32'd0);

    // Low stop bit.
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    idle(20);
    check("s3_count", 32'(count), 32'd0);
    check("s3_frame_error", 32'(frame_error), 32'd1);
    check("s3_overrun", 32'(overrun), 32'd0);
    pulse_clr();
    check("s3_frame_error_clr", 32'(frame_error), 32'd0);

    // Short low glitch while idle, then a real frame proves the FSM is back in IDLE.
    rx = 1'b0;
    repeat (3) @(negedge clk);
    idle(30);
    check("s4_count", 32'(count), 32'd0);
    check("s4_frame_error", 32'(frame_error), 32'd0);
    check("s4_overrun", 32'(overrun), 32'd0);
    send_frame(8'h81, 1'b1, 1'b1, 1'b0);
    idle(5);
    check("s4_after_count", 32'(count), 32'd1);
    drain("s4");

    // Full FIFO with a pop on the stop-sample cycle.
    for (int i = 0; i < 16; i++) send_frame(8'(8'h20 + i), 1'b1, 1'b1, 1'b0);
    check("s5_full_before", 32'(full), 32'd1);
    send_frame(8'h77, 1'b1, 1'b1, 1'b1);
    idle(5);
    check("s5_count", 32'(count), 32'd16);
    check("s5_full", 32'(full), 32'd1);
    check("s5_overrun", 32'(overrun), 32'd0);
    drain("s5");

    // Reset mid-frame with a byte queued and frame_error set.
    send_frame(8'h99, 1'b1, 1'b1, 1'b0);
    send_frame(8'hEE, 1'b0, 1'b0, 1'b0);
    idle(20);
    check("s6_pre_count", 32'(count), 32'd1);
    check("s6_pre_frame_error", 32'(frame_error), 32'd1);
    rx = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = (8'h55 >> i) & 8'h01;
      repeat (10) @(negedge clk);
    end
    reset = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    check("s6_rst_empty", 32'(empty), 32'd1);
    check("s6_rst_count", 32'(count), 32'd0);
    check("s6_rst_frame_error", 32'(frame_error), 32'd0);
    check("s6_rst_rd_data", 32'(rd_data), 32'h00);
    rx = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    idle(120);
    check("s6_idle_count", 32'(count), 32'd0);
    check("s6_idle_frame_error", 32'(frame_error), 32'd0);
    send_frame(8'h12, 1'b1, 1'b1, 1'b0);
    idle(5);
    check("s6_count", 32'(count), 32'd1);
    check("s6_head", 32'(rd_data), 32'h12);
    check("s6_frame_error", 32'(frame_error), 32'd0);
    check("s6_overrun", 32'(overrun), 32'd0);
    drain("s6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
